rob: RTL and testbench
======================

# rob

Reorder buffer for the out-of-order core: the responder end of the decode stage's ROB-position handshake. It hands out instruction tags and accepts allocations of destination register and op from decode. It records results broadcast on the writeback bus and retires entries in program order to the register file. Sits between `id` (allocation), the execution units' writeback bus, and `reg_file` (commit).

## Interface
- `DEPTH`, 8: number of entries; tags are `1..DEPTH`, tag 0 is `TAG_INVALID`.
- `TAG_W`, `INST_TAG_WIDTH`: tag width; must satisfy `2**TAG_W > DEPTH`.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous squash of all entries (mispredict recovery).
- `alloc_req` in 1: decode requests an entry this cycle (tag_token).
- `alloc_rd` in `REG_NUM_WIDTH`: destination register of the allocating instruction.
- `alloc_op` in `OP_TYPE_WIDTH`: op of the allocating instruction.
- `avail_tag` out `TAG_W`: tag the next allocation will receive; combinational, `TAG_INVALID` when full.
- `full` out 1: no free entry; combinational from count.
- `wb_en` in 1: writeback valid.
- `wb_tag` in `TAG_W`: tag being completed.
- `wb_val` in `COMMON_WIDTH`: result value.
- `commit_en` out 1: one entry retired (registered pulse).
- `commit_we` out 1: retired entry writes the register file (`rd != 0`).
- `commit_rd` out `REG_NUM_WIDTH`, `commit_tag` out `TAG_W`, `commit_val` out `COMMON_WIDTH`: retired entry's fields; `reg_file` clears its tag for `commit_rd` only if it equals `commit_tag`.

## Operation
- Circular buffer, `head` (oldest) and `tail` (next free) indices `0..DEPTH-1`; tag = index + 1. `count` `0..DEPTH`.
- Entry fields: `busy`, `ready`, `rd`, `op`, `val`.
- Allocate: `alloc_req && !full` at edge → entry[tail] busy=1, ready=0, rd/op latched; tail advances, wrapping `DEPTH-1 → 0`. `alloc_req` while full is ignored; decode holds its request.
- Writeback: `wb_en` with `wb_tag` in `1..DEPTH` whose entry is busy → ready=1, val=`wb_val`. Tag 0, out-of-range tags and non-busy entries are ignored. A second writeback to the same tag overwrites `val`.
- Commit: when entry[head] is busy and ready → registered `commit_*` driven from it for exactly one cycle; entry cleared; head advances with wrap. At most one commit per cycle.
- `full = (count == DEPTH)`; count is updated by `+alloc −commit` in the same edge.
- Allocate and commit in the same edge leave count unchanged. `full` is evaluated on the pre-edge count, so a freeing commit does not unblock allocation in that same cycle.
- Priority: `rst` > `flush` > normal operation. Flush clears all busy/ready, head=tail=count=0, and drops any simultaneous alloc, writeback or commit. Outputs return to reset values at the next edge.
- Reset values: `commit_en=0`, `commit_we=0`, `commit_rd=0`, `commit_tag=0`, `commit_val=0`. Buffer is empty, so `full=0` and `avail_tag=1`.

## Timing
- Allocation latency: tag returned combinationally in the request cycle; entry valid after the edge.
- Writeback to commit: writeback at edge N marks the head ready; `commit_en` is high in the cycle after edge N+1 (2-edge minimum; see Configuration).
- Peak throughput: 1 alloc + 1 writeback + 1 commit per cycle.
- `avail_tag` and `full` may change only after a posedge.

## Configuration
- `ROB_COMMIT_BYPASS_EN` defined: a writeback whose tag equals the head tag, while the head is busy and not ready, commits at that same edge. `commit_val = wb_val`, so `commit_en` is high after edge N. The entry is retired without passing through the ready state.
- Undefined: no bypass; commit always comes from a stored ready entry, giving the 2-edge latency.

## Structure
- `common_def.h`: `TAG_INVALID`, `INST_TAG_WIDTH`, `COMMON_WIDTH`, `REG_NUM_WIDTH`, `OP_TYPE_WIDTH`.
- Shared package `rob_pkg`: `rob_entry_t` struct (`busy`, `ready`, `rd`, `op`, `val`) and tag↔index conversion functions.
- Sub-module `rob_ptr`: wrapping index counter with an increment enable and synchronous clear; instantiated for head and tail.

## Test plan
- Reset, then alloc rd=3 → `avail_tag` 1 before the edge and 2 after. `wb_tag=1`, `wb_val=0xDEAD` → `commit_en=1`, `commit_rd=3`, `commit_tag=1`, `commit_val=0xDEAD` (edge count per macro).
- Fill 8 entries → `full=1`, `avail_tag=0`; a 9th `alloc_req` is ignored. Complete tag 1, and after commit `full=0` with `avail_tag=1` (wrap).
- Alloc tags 1,2,3; write back 3, then 2, then 1 → commits in order 1,2,3 on consecutive cycles.
- Alloc rd=0, write back → `commit_en=1`, `commit_we=0`.
- `wb_en` with tag 0, then with tag 5 while only tags 1–2 are busy → no state change, no commit.
- Alloc 4 entries, assert `flush` in the same cycle as `alloc_req` and a writeback to the head → empty, `avail_tag=1`, no commit. Repeat with `rst` mid-stream.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared ROB definitions: field widths, entry record and tag/index conversion.
package rob_pkg;

   localparam int TAG_INVALID    = 0;
   localparam int INST_TAG_WIDTH = 4;
   localparam int COMMON_WIDTH   = 32;
   localparam int REG_NUM_WIDTH  = 5;
   localparam int OP_TYPE_WIDTH  = 4;
   localparam int ROB_DEPTH      = 8;

   typedef struct packed {
      logic                     busy;
      logic                     ready;
      logic [REG_NUM_WIDTH-1:0] rd;
      logic [OP_TYPE_WIDTH-1:0] op;
      logic [COMMON_WIDTH-1:0]  val;
   } rob_entry_t;

   // Tag 0 is reserved, so tag = index + 1.
   function automatic logic [INST_TAG_WIDTH-1:0] idx2tag(input logic [INST_TAG_WIDTH-1:0] idx);
      return idx + 1'b1;
   endfunction

   function automatic logic [INST_TAG_WIDTH-1:0] tag2idx(input logic [INST_TAG_WIDTH-1:0] tag);
      return tag - 1'b1;
   endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrapping index counter 0..DEPTH-1 with increment enable and synchronous clear.
module rob_ptr #(
   parameter int DEPTH = 8,
   parameter int W     = $clog2(DEPTH)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] idx_o
);

   logic [W-1:0] idx_q, idx_d;

   always_comb begin
      idx_d = idx_q;
      if (inc_i) idx_d = (idx_q == W'(DEPTH - 1)) ? '0 : idx_q + 1'b1;
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) idx_q <= '0;
      else                idx_q <= idx_d;
   end

   assign idx_o = idx_q;

endmodule

// File: rtl/rob.sv
// Reorder buffer: tag allocation, writeback capture and in-order commit.
// Optional same-edge commit of a head writeback: define ROB_COMMIT_BYPASS_EN.
module rob
   import rob_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int TAG_W = INST_TAG_WIDTH
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     alloc_req_i,
   input  logic [REG_NUM_WIDTH-1:0] alloc_rd_i,
   input  logic [OP_TYPE_WIDTH-1:0] alloc_op_i,
   output logic [TAG_W-1:0]         avail_tag_o,
   output logic                     full_o,
   input  logic                     wb_en_i,
   input  logic [TAG_W-1:0]         wb_tag_i,
   input  logic [COMMON_WIDTH-1:0]  wb_val_i,
   output logic                     commit_en_o,
   output logic                     commit_we_o,
   output logic [REG_NUM_WIDTH-1:0] commit_rd_o,
   output logic [TAG_W-1:0]         commit_tag_o,
   output logic [COMMON_WIDTH-1:0]  commit_val_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   rob_entry_t entries_q [DEPTH];
   rob_entry_t entries_d [DEPTH];
   rob_entry_t head_e;
   logic [CNT_W-1:0] count_q, count_d;
   logic [IDX_W-1:0] head_idx, tail_idx, wb_idx;
   logic [TAG_W-1:0] head_tag, tail_tag;
   logic full, do_alloc, wb_in_range, wb_hit, bypass, do_commit;

   logic                     commit_en_q, commit_en_d, commit_we_q, commit_we_d;
   logic [REG_NUM_WIDTH-1:0] commit_rd_q, commit_rd_d;
   logic [TAG_W-1:0]         commit_tag_q, commit_tag_d;
   logic [COMMON_WIDTH-1:0]  commit_val_q, commit_val_d;

   rob_ptr #(.DEPTH(DEPTH)) u_head (
      .clk_i(clk_i), .rst_i(rst_i), .clr_i(flush_i), .inc_i(do_commit), .idx_o(head_idx)
   );
   rob_ptr #(.DEPTH(DEPTH)) u_tail (
      .clk_i(clk_i), .rst_i(rst_i), .clr_i(flush_i), .inc_i(do_alloc), .idx_o(tail_idx)
   );

   assign head_tag    = TAG_W'(idx2tag(INST_TAG_WIDTH'(head_idx)));
   assign tail_tag    = TAG_W'(idx2tag(INST_TAG_WIDTH'(tail_idx)));
   assign wb_idx      = IDX_W'(tag2idx(INST_TAG_WIDTH'(wb_tag_i)));
   assign head_e      = entries_q[head_idx];

   assign full        = (count_q == CNT_W'(DEPTH));
   assign full_o      = full;
   assign avail_tag_o = full ? TAG_W'(TAG_INVALID) : tail_tag;
   assign do_alloc    = alloc_req_i && !full;

   assign wb_in_range = (wb_tag_i != TAG_W'(TAG_INVALID)) && (wb_tag_i <= TAG_W'(DEPTH));
   assign wb_hit      = wb_en_i && wb_in_range && entries_q[wb_idx].busy;

`ifdef ROB_COMMIT_BYPASS_EN
   assign bypass = wb_hit && (wb_idx == head_idx) && !head_e.ready;
`else
   assign bypass = 1'b0;
`endif
   assign do_commit = (head_e.busy && head_e.ready) || bypass;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      entries_d = entries_q;
      if (wb_hit) begin
         entries_d[wb_idx].ready = 1'b1;
         entries_d[wb_idx].val   = wb_val_i;
      end
      if (do_commit) entries_d[head_idx] = '0;
      if (do_alloc) begin
         entries_d[tail_idx]      = '0;
         entries_d[tail_idx].busy = 1'b1;
         entries_d[tail_idx].rd   = alloc_rd_i;
         entries_d[tail_idx].op   = alloc_op_i;
      end
      count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_commit);

      commit_en_d  = 1'b0;
      commit_we_d  = 1'b0;
      commit_rd_d  = '0;
      commit_tag_d = '0;
      commit_val_d = '0;
      if (do_commit) begin
         commit_en_d  = 1'b1;
         commit_we_d  = (head_e.rd != '0);
         commit_rd_d  = head_e.rd;
         commit_tag_d = head_tag;
         commit_val_d = bypass ? wb_val_i : head_e.val;
      end
   end

   // NOTE: the whole entry array is cleared, not just busy/ready, so stale rd/val never survive a flush.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
         count_q      <= '0;
         commit_en_q  <= 1'b0;
         commit_we_q  <= 1'b0;
         commit_rd_q  <= '0;
         commit_tag_q <= '0;
         commit_val_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
         count_q      <= count_d;
         commit_en_q  <= commit_en_d;
         commit_we_q  <= commit_we_d;
         commit_rd_q  <= commit_rd_d;
         commit_tag_q <= commit_tag_d;
         commit_val_q <= commit_val_d;
      end
   end

   assign commit_en_o  = commit_en_q;
   assign commit_we_o  = commit_we_q;
   assign commit_rd_o  = commit_rd_q;
   assign commit_tag_o = commit_tag_q;
   assign commit_val_o = commit_val_q;

endmodule

// File: tb/tb_rob.sv
// Bench for rob: directed steps then random traffic, checked against a
// program-order queue model of the buffer.
module tb_rob;
   import rob_pkg::*;

   localparam int DEPTH = ROB_DEPTH;

   logic                     clk = 1'b0;
   logic                     rst_i, flush_i, alloc_req_i, wb_en_i;
   logic [REG_NUM_WIDTH-1:0] alloc_rd_i;
   logic [OP_TYPE_WIDTH-1:0] alloc_op_i;
   logic [INST_TAG_WIDTH-1:0] avail_tag_o, wb_tag_i, commit_tag_o;
   logic                     full_o, commit_en_o, commit_we_o;
   logic [COMMON_WIDTH-1:0]  wb_val_i, commit_val_o;
   logic [REG_NUM_WIDTH-1:0] commit_rd_o;

   rob dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
      .alloc_req_i(alloc_req_i), .alloc_rd_i(alloc_rd_i), .alloc_op_i(alloc_op_i),
      .avail_tag_o(avail_tag_o), .full_o(full_o),
      .wb_en_i(wb_en_i), .wb_tag_i(wb_tag_i), .wb_val_i(wb_val_i),
      .commit_en_o(commit_en_o), .commit_we_o(commit_we_o), .commit_rd_o(commit_rd_o),
      .commit_tag_o(commit_tag_o), .commit_val_o(commit_val_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          tag;
      int          rd;
      bit          rdy;
      int unsigned val;
   } m_t;

   m_t mq[$];
   int next_tag = 1;
   int n_chk = 0;
   int n_pass = 0;
   int commits = 0;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
   endtask

   // One clock cycle: drive at negedge, check combinational outputs, advance
   // the model, then check the registered commit outputs after the edge.
   task automatic step(input bit a, input int rd, input bit we, input int wt,
                       input logic [31:0] wv, input bit fl, input bit r);
      bit exp_full, exp_en;
      int exp_avail;
      m_t c;
      alloc_req_i = a;
      alloc_rd_i  = REG_NUM_WIDTH'(rd);
      alloc_op_i  = OP_TYPE_WIDTH'($urandom);
      wb_en_i     = we;
      wb_tag_i    = INST_TAG_WIDTH'(wt);
      wb_val_i    = wv;
      flush_i     = fl;
      rst_i       = r;
      #1;
      exp_full  = (mq.size() == DEPTH);
      exp_avail = exp_full ? TAG_INVALID : next_tag;
      check("full", 32'(full_o), 32'(exp_full));
      check("avail_tag", 32'(avail_tag_o), exp_avail);
      exp_en = 1'b0;
      c = '{0, 0, 1'b0, 0};
      if (r || fl) begin
         mq.delete();
         next_tag = 1;
      end else begin
         if (mq.size() > 0 && mq[0].rdy) begin
            exp_en = 1'b1;
            c = mq[0];
         end
`ifdef ROB_COMMIT_BYPASS_EN
         else if (mq.size() > 0 && we && wt == mq[0].tag) begin
            exp_en = 1'b1;
            c = mq[0];
            c.val = wv;
         end
`endif
         if (exp_en) void'(mq.pop_front());
         if (we) foreach (mq[i]) if (mq[i].tag == wt) begin
            mq[i].rdy = 1'b1;
            mq[i].val = wv;
         end
         if (a && !exp_full) begin
            mq.push_back('{next_tag, rd, 1'b0, 0});
            next_tag = (next_tag == DEPTH) ? 1 : next_tag + 1;
         end
      end
      @(posedge clk);
      #1;
      check("commit_en", 32'(commit_en_o), 32'(exp_en));
      if (exp_en) begin
         commits++;
         check("commit_tag", 32'(commit_tag_o), c.tag);
         check("commit_rd", 32'(commit_rd_o), c.rd);
         check("commit_val", commit_val_o, c.val);
         check("commit_we", 32'(commit_we_o), 32'(c.rd != 0));
      end
      @(negedge clk);
      alloc_req_i = 1'b0;
      wb_en_i     = 1'b0;
      flush_i     = 1'b0;
      rst_i       = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int h, t, c0;
      rst_i = 1'b1; flush_i = 1'b0; alloc_req_i = 1'b0; alloc_rd_i = '0;
      alloc_op_i = '0; wb_en_i = 1'b0; wb_tag_i = '0; wb_val_i = '0;
      @(negedge clk);

      // Reset values.
      step(0, 0, 0, 0, 0, 0, 1);
      check("rst_avail", 32'(avail_tag_o), 1);
      check("rst_full", 32'(full_o), 0);
      check("rst_commit_en", 32'(commit_en_o), 0);
      check("rst_commit_we", 32'(commit_we_o), 0);
      check("rst_commit_rd", 32'(commit_rd_o), 0);
      check("rst_commit_tag", 32'(commit_tag_o), 0);
      check("rst_commit_val", commit_val_o, 0);

      // First allocation and writeback-to-commit latency.
      step(1, 3, 0, 0, 0, 0, 0);
      check("avail_after_alloc", 32'(avail_tag_o), 2);
      c0 = commits;
      step(0, 0, 1, 1, 32'hDEAD, 0, 0);
      idle(2);
      check("first_commit_seen", commits - c0, 1);

      // Fill, ignored 9th request, wrap after freeing tag 1.
      step(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < DEPTH; i++) step(1, i + 1, 0, 0, 0, 0, 0);
      check("fill_full", 32'(full_o), 1);
      check("fill_avail", 32'(avail_tag_o), 0);
      step(1, 9, 0, 0, 0, 0, 0);
      step(0, 0, 1, 1, 32'h1111, 0, 0);
      idle(2);
      check("wrap_full", 32'(full_o), 0);
      check("wrap_avail", 32'(avail_tag_o), 1);
      step(0, 0, 0, 0, 0, 1, 0);

      // Out-of-order completion, in-order retirement.
      for (int i = 0; i < 3; i++) step(1, 10 + i, 0, 0, 0, 0, 0);
      c0 = commits;
      step(0, 0, 1, 3, 32'h3333, 0, 0);
      step(0, 0, 1, 2, 32'h2222, 0, 0);
      step(0, 0, 1, 1, 32'h0101, 0, 0);
      idle(4);
      check("inorder_commits", commits - c0, 3);

      // rd = 0 retires without a register write.
      t = next_tag;
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, t, 32'hBEEF, 0, 0);
      idle(2);

      // Ignored writebacks: tag 0 and a non-busy tag.
      step(0, 0, 0, 0, 0, 1, 0);
      step(1, 4, 0, 0, 0, 0, 0);
      step(1, 5, 0, 0, 0, 0, 0);
      c0 = commits;
      step(0, 0, 1, 0, 32'hAAAA, 0, 0);
      step(0, 0, 1, 5, 32'hBBBB, 0, 0);
      idle(3);
      check("ignored_wb_no_commit", commits - c0, 0);
      step(0, 0, 1, 1, 32'h5, 0, 0);
      step(0, 0, 1, 2, 32'h6, 0, 0);
      idle(3);

      // Flush with simultaneous alloc and head writeback.
      for (int i = 0; i < 4; i++) step(1, 20 + i, 0, 0, 0, 0, 0);
      h = mq[0].tag;
      step(1, 7, 1, h, 32'hF00D, 1, 0);
      check("flush_avail", 32'(avail_tag_o), 1);
      check("flush_full", 32'(full_o), 0);
      idle(2);

      // Reset mid-stream.
      for (int i = 0; i < 3; i++) step(1, 24 + i, 0, 0, 0, 0, 0);
      step(0, 0, 1, 1, 32'h77, 0, 0);
      step(1, 8, 1, 2, 32'h88, 0, 1);
      check("rst_mid_avail", 32'(avail_tag_o), 1);
      idle(2);

      // Random traffic.
      for (int n = 0; n < 500; n++) begin
         bit a, we, fl, r;
         int wt;
         a  = ($urandom_range(0, 9) < 7);
         we = ($urandom_range(0, 3) != 0);
         if (mq.size() > 0 && $urandom_range(0, 3) != 0)
            wt = mq[$urandom_range(0, mq.size() - 1)].tag;
         else
            wt = $urandom_range(0, 15);
         fl = ($urandom_range(0, 99) == 0);
         r  = ($urandom_range(0, 199) == 0);
         step(a, $urandom_range(0, 31), we, wt, $urandom, fl, r);
      end
      idle(12);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
